// File: rtl/ex_stage.sv
// Two-stage execute pipeline: decode feeds stage 1 registers, the ALU result lands in stage 2.
// Both stages use valid/ready handshaking; only the stage 2 registers drive the outputs.

module alu #(
   parameter int W = 32
) (
   input  logic [3:0]   ctl,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y,
   output logic         zero
);

   always_comb begin
      y = '0;
      case (ctl)
         4'b0000: y = a & b;
         4'b0001: y = a | b;
         4'b0010: y = a + b;
         4'b0110: y = a - b;
         4'b0111: y = (a < b) ? {{(W-1){1'b0}}, 1'b1} : '0;
         4'b1100: y = ~(a | b);
         default: y = '0;
      endcase
   end

   assign zero = (y == '0);

endmodule

module ex_stage #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   aluop,
   input  logic [2:0]   funct3,
   input  logic         funct7_5,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic [4:0]   rd_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         zero,
   output logic         branch_taken,
   output logic         illegal,
   output logic [4:0]   rd_out
);

   // Returns {illegal, ALUctl}; unsupported encodings fall back to AND.
   function automatic logic [4:0] decode(input logic [1:0] op, input logic [2:0] f3,
                                         input logic f7);
      logic [4:0] d;
      d = 5'b1_0000;
      case (op)
         2'b00: d = 5'b0_0010;
         2'b01: d = 5'b0_0110;
         2'b10: begin
            case ({f3, f7})
               4'b000_0: d = 5'b0_0010;
               4'b000_1: d = 5'b0_0110;
               4'b111_0: d = 5'b0_0000;
               4'b110_0: d = 5'b0_0001;
               4'b010_0: d = 5'b0_0111;
               4'b100_1: d = 5'b0_1100;
               default:  d = 5'b1_0000;
            endcase
         end
         default: d = 5'b1_0000;
      endcase
      return d;
   endfunction

   logic [4:0]   dec;
   logic         adv2;

   logic         vld_p1;
   logic [3:0]   ctl_p1;
   logic [W-1:0] a_p1;
   logic [W-1:0] b_p1;
   logic [4:0]   rd_p1;
   logic         br_p1;
   logic         ill_p1;

   logic [W-1:0] alu_y;
   logic         alu_zero;
   logic         vld_p2;

   assign dec       = decode(aluop, funct3, funct7_5);
   assign adv2      = !vld_p2 || out_ready;
   assign in_ready  = !vld_p1 || adv2;
   assign out_valid = vld_p2;

   // Stage 1: decoded operation and operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        vld_p1 <= 1'b0;
      else if (in_ready) vld_p1 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (in_ready) begin
         ctl_p1 <= dec[3:0];
         ill_p1 <= dec[4];
         a_p1   <= op_a;
         b_p1   <= op_b;
         rd_p1  <= rd_in;
         br_p1  <= (aluop == 2'b01);
      end
   end

   alu #(.W(W)) u_alu (
      .ctl  (ctl_p1),
      .a    (a_p1),
      .b    (b_p1),
      .y    (alu_y),
      .zero (alu_zero)
   );

   // Stage 2: registered ALU outputs presented to write-back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2       <= 1'b0;
         result       <= '0;
         zero         <= 1'b0;
         branch_taken <= 1'b0;
         illegal      <= 1'b0;
         rd_out       <= '0;
      end else if (adv2) begin
         vld_p2       <= vld_p1;
         result       <= alu_y;
         zero         <= alu_zero;
         branch_taken <= br_p1 && alu_zero;
         illegal      <= ill_p1;
         rd_out       <= rd_p1;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a driver pushes expected results on each accepted operation,
// a monitor pops and compares whenever write-back takes a result.

module tb_ex_stage;

   typedef struct packed {
      logic [1:0]  aluop;
      logic [2:0]  f3;
      logic        f75;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
   } op_t;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        br;
      logic        ill;
      logic [4:0]  rd;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  aluop;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  rd_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        branch_taken;
   logic        illegal;
   logic [4:0]  rd_out;

   int   checks = 0;
   int   passes = 0;
   int   mode   = 1;   // 0 random out_ready, 1 always ready, 2 never ready
   exp_t q[$];

   ex_stage #(.W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .aluop        (aluop),
      .funct3       (funct3),
      .funct7_5     (funct7_5),
      .op_a         (op_a),
      .op_b         (op_b),
      .rd_in        (rd_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .zero         (zero),
      .branch_taken (branch_taken),
      .illegal      (illegal),
      .rd_out       (rd_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no completion, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
   endtask

   // Reference behaviour: what the instruction means, not how the pipeline computes it.
   function automatic exp_t model(input op_t o);
      exp_t e;
      logic [31:0] r;
      logic ill;
      ill = 1'b0;
      r   = o.a & o.b;
      if (o.aluop == 2'd0)      r = o.a + o.b;
      else if (o.aluop == 2'd1) r = o.a - o.b;
      else if (o.aluop == 2'd3) ill = 1'b1;
      else begin
         if      (o.f3 == 3'd0 && !o.f75) r = o.a + o.b;
         else if (o.f3 == 3'd0 &&  o.f75) r = o.a - o.b;
         else if (o.f3 == 3'd7 && !o.f75) r = o.a & o.b;
         else if (o.f3 == 3'd6 && !o.f75) r = o.a | o.b;
         else if (o.f3 == 3'd2 && !o.f75) r = (o.a < o.b) ? 32'd1 : 32'd0;
         else if (o.f3 == 3'd4 &&  o.f75) r = ~(o.a | o.b);
         else ill = 1'b1;
      end
      e.res = r;
      e.z   = (r == 32'd0);
      e.br  = (o.aluop == 2'd1) && (r == 32'd0);
      e.ill = ill;
      e.rd  = o.rd;
      return e;
   endfunction

   function automatic op_t mk(input logic [1:0] al, input logic [2:0] f3, input logic f7,
                              input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      op_t o;
      o.aluop = al; o.f3 = f3; o.f75 = f7; o.a = a; o.b = b; o.rd = rd;
      return o;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      logic [3:0] legal [6];
      int k;
      legal = '{4'b0000, 4'b0001, 4'b1110, 4'b1100, 4'b0100, 4'b1001};
      o.aluop = 2'($urandom_range(0, 3));
      o.f3    = 3'($urandom_range(0, 7));
      o.f75   = 1'($urandom_range(0, 1));
      if (o.aluop == 2'd2 && $urandom_range(0, 3) != 0) begin
         k = $urandom_range(0, 5);
         {o.f3, o.f75} = legal[k];
      end
      o.a  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      o.b  = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
      o.rd = 5'($urandom_range(0, 31));
      return o;
   endfunction

   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (mode == 1)      out_ready = 1'b1;
         else if (mode == 2) out_ready = 1'b0;
         else                out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: compares every transfer to the scoreboard and checks outputs hold under stall.
   initial begin
      exp_t e;
      exp_t held;
      bit   held_v;
      held_v = 1'b0;
      held   = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) held_v = 1'b0;
         else begin
            if (held_v) begin
               chk("hold_valid", 64'(out_valid), 64'd1);
               chk("hold_payload", 64'({result, zero, branch_taken, illegal, rd_out}), 64'(held));
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
               else begin
                  e = q.pop_front();
                  chk("result", 64'(result), 64'(e.res));
                  chk("zero", 64'(zero), 64'(e.z));
                  chk("branch_taken", 64'(branch_taken), 64'(e.br));
                  chk("illegal", 64'(illegal), 64'(e.ill));
                  chk("rd_out", 64'(rd_out), 64'(e.rd));
               end
            end
            held_v = out_valid && !out_ready;
            held   = {result, zero, branch_taken, illegal, rd_out};
         end
      end
   end

   task automatic send(input op_t o, output bit first);
      @(negedge clk);
      in_valid = 1'b1;
      aluop = o.aluop; funct3 = o.f3; funct7_5 = o.f75;
      op_a = o.a; op_b = o.b; rd_in = o.rd;
      #1;
      first = in_ready;
      for (int i = 0; i < 100 && !in_ready; i++) begin
         @(negedge clk);
         #1;
      end
      if (in_ready) q.push_back(model(o));
      else chk("accept_timeout", 64'(in_ready), 64'd1);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         #3;
         if (q.size() == 0 && !out_valid) done = 1'b1;
      end
      if (!done) chk("drain_timeout", 64'(q.size()), 64'd0);
   endtask

   // Directed op with fixed expected values and exact two-edge latency.
   task automatic directed(input string name, input op_t o, input logic [31:0] r,
                           input logic z, input logic br, input logic il);
      bit f;
      send(o, f);
      idle();
      #3;
      chk({name, "_lat_early"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      #3;
      chk({name, "_lat_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_res"}, 64'(result), 64'(r));
      chk({name, "_zero"}, 64'(zero), 64'(z));
      chk({name, "_br"}, 64'(branch_taken), 64'(br));
      chk({name, "_ill"}, 64'(illegal), 64'(il));
   endtask

   initial begin
      bit f, f1, f2, f3b, all_first;
      int run;
      exp_t first_exp;

      rst_n = 1'b0; in_valid = 1'b0; aluop = '0; funct3 = '0; funct7_5 = 1'b0;
      op_a = '0; op_b = '0; rd_in = '0;
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_outputs", 64'({result, zero, branch_taken, illegal, rd_out}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      mode = 1;
      repeat (2) @(negedge clk);
      directed("add", mk(2'd2, 3'd0, 1'b0, 32'd5, 32'd7, 5'd3), 32'd12, 1'b0, 1'b0, 1'b0);
      directed("beq", mk(2'd1, 3'd0, 1'b0, 32'h1234, 32'h1234, 5'd4), 32'd0, 1'b1, 1'b1, 1'b0);
      directed("bne", mk(2'd1, 3'd0, 1'b0, 32'h1234, 32'h1235, 5'd5), 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      directed("slt", mk(2'd2, 3'd2, 1'b0, 32'd3, 32'd9, 5'd6), 32'd1, 1'b0, 1'b0, 1'b0);
      directed("nor", mk(2'd2, 3'd4, 1'b1, 32'd0, 32'd0, 5'd7), 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      directed("rsvd", mk(2'd3, 3'd0, 1'b0, 32'hF0F0, 32'h0FF0, 5'd8), 32'h00F0, 1'b0, 1'b0, 1'b1);
      drain();

      // Back-pressure: two accepts fill the pipe, the third waits until release.
      mode = 2;
      send(rand_op(), f1);
      first_exp = q[0];
      send(rand_op(), f2);
      chk("bp_accept1", 64'(f1), 64'd1);
      chk("bp_accept2", 64'(f2), 64'd1);
      fork
         send(rand_op(), f3b);
         begin
            repeat (4) @(negedge clk);
            #1;
            chk("bp_full_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_holds_first", 64'(result), 64'(first_exp.res));
            mode = 1;
         end
      join
      chk("bp_third_stalled", 64'(f3b), 64'd0);
      idle();
      drain();

      // Full-rate stream.
      mode = 1;
      all_first = 1'b1;
      run = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               send(rand_op(), f);
               all_first &= f;
            end
            idle();
         end
         begin
            for (int i = 0; i < 20 && !out_valid; i++) begin
               @(negedge clk);
               #3;
            end
            while (out_valid && run < 20) begin
               run++;
               @(negedge clk);
               #3;
            end
         end
      join
      chk("stream_in_ready", 64'(all_first), 64'd1);
      chk("stream_run", 64'(run), 64'd8);
      drain();

      // Reset with both stages occupied.
      mode = 2;
      send(rand_op(), f);
      send(rand_op(), f);
      idle();
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_outputs", 64'({result, zero, branch_taken, illegal, rd_out}), 64'd0);
      q.delete();
      mode = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #3;
         if (out_valid) run++;
      end
      chk("postrst_no_stale", 64'(run), 64'd0);
      directed("postrst_add", mk(2'd0, 3'd5, 1'b1, 32'hFFFF_FFFF, 32'd2, 5'd9), 32'd1, 1'b0, 1'b0, 1'b0);
      drain();

      // Randomized traffic with random back-pressure.
      mode = 0;
      for (int i = 0; i < 200; i++) begin
         send(rand_op(), f);
         if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      idle();
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
